// File: rtl/fetch_select_align_pkg.sv
// Shared fetch-path definitions: default configuration, derived widths,
// the queued bundle layout and the output-queue occupancy states.
package fetch_select_align_pkg;

    localparam int unsigned DEF_SIZE_PC     = 32;
    localparam int unsigned DEF_INST_WIDTH  = 32;
    localparam int unsigned DEF_FETCH_WIDTH = 4;
    localparam int unsigned DEF_NUM_BANKS   = 2;
    localparam int unsigned DEF_BLOCK_INSTS = 4;

    localparam int unsigned FIRST_BITS = $clog2(DEF_BLOCK_INSTS);
    localparam int unsigned BANK_BITS  = $clog2(DEF_NUM_BANKS);
    localparam int unsigned CNT_BITS   = $clog2(DEF_FETCH_WIDTH) + 1;

    // Bundle layout for the default configuration.
    typedef struct packed {
        logic [DEF_FETCH_WIDTH*DEF_INST_WIDTH-1:0] inst;
        logic [DEF_FETCH_WIDTH-1:0]                mask;
        logic [DEF_SIZE_PC-1:0]                    pc;
        logic [CNT_BITS-1:0]                       count;
    } fetch_bundle_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/fetch_select_align_rotate.sv
// Combinational window rotate/shift: picks up to FETCH_WIDTH consecutive
// instructions starting at the fetch PC across the interleaved banks and
// truncates the bundle at the first missing bank or the predicted-taken slot.
module fetch_align_rotate
    import fetch_select_align_pkg::*;
#(
    parameter int unsigned SIZE_PC     = DEF_SIZE_PC,
    parameter int unsigned INST_WIDTH  = DEF_INST_WIDTH,
    parameter int unsigned FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int unsigned NUM_BANKS   = DEF_NUM_BANKS,
    parameter int unsigned BLOCK_INSTS = DEF_BLOCK_INSTS
) (
    input  logic [SIZE_PC-1:0]                          pc_i,
    input  logic [NUM_BANKS*BLOCK_INSTS*INST_WIDTH-1:0] bank_data_i,
    input  logic [NUM_BANKS-1:0]                        bank_valid_i,
    input  logic                                        taken_valid_i,
    input  logic [$clog2(FETCH_WIDTH)-1:0]              taken_slot_i,
    output logic [FETCH_WIDTH*INST_WIDTH-1:0]           inst_o,
    output logic [FETCH_WIDTH-1:0]                      mask_o,
    output logic [$clog2(FETCH_WIDTH):0]                count_o
);

    localparam int unsigned WIN     = NUM_BANKS * BLOCK_INSTS;
    localparam int unsigned FIRST_W = $clog2(BLOCK_INSTS);
    localparam int unsigned BANK_W  = $clog2(NUM_BANKS);
    localparam int unsigned CNT_W   = $clog2(FETCH_WIDTH) + 1;

    logic [INST_WIDTH-1:0] blocks [NUM_BANKS][BLOCK_INSTS];
    logic [INST_WIDTH-1:0] slots  [FETCH_WIDTH];
    logic [BANK_W-1:0]     slot_bank [FETCH_WIDTH];
    logic [FIRST_W-1:0]    slot_idx  [FETCH_WIDTH];
    logic [FIRST_W-1:0]    first;
    logic [BANK_W-1:0]     start;
    int unsigned           lim;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar k = 0; k < BLOCK_INSTS; k++) begin : g_slot
            assign blocks[b][k] = bank_data_i[(b*BLOCK_INSTS+k)*INST_WIDTH +: INST_WIDTH];
        end
    end

    for (genvar s = 0; s < FETCH_WIDTH; s++) begin : g_out
        assign inst_o[s*INST_WIDTH +: INST_WIDTH] = slots[s];
    end

    // Map each bundle slot to (bank, index) and derive the bundle length.
    // Bank index arithmetic wraps modulo NUM_BANKS through the BANK_W truncation.
    always_comb begin
        first     = pc_i[2 +: FIRST_W];
        start     = pc_i[2+FIRST_W +: BANK_W];
        slot_bank = '{default: '0};
        slot_idx  = '{default: '0};
        slots     = '{default: '0};
        mask_o    = '0;
        lim       = FETCH_WIDTH;
        if (WIN - 32'(first) < lim) begin
            lim = WIN - 32'(first);
        end
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            slot_bank[i] = start + BANK_W'((32'(first) + i) >> FIRST_W);
            slot_idx[i]  = FIRST_W'(32'(first) + i);
            if (i < lim && !bank_valid_i[slot_bank[i]]) begin
                lim = i;
            end
        end
        if (taken_valid_i && (32'(taken_slot_i) + 1 < lim)) begin
            lim = 32'(taken_slot_i) + 1;
        end
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            mask_o[i] = (i < lim);
            slots[i]  = mask_o[i] ? blocks[slot_bank[i]][slot_idx[i]] : '0;
        end
        count_o = CNT_W'(lim);
    end

endmodule

// File: rtl/fetch_select_align.sv
// Fetch bundle selector/aligner: aligns banked I-cache blocks into a bundle
// and buffers bundles in a 2-entry FIFO toward decode, with flush and miss pulse.
module fetch_select_align
    import fetch_select_align_pkg::*;
#(
    parameter int unsigned SIZE_PC     = DEF_SIZE_PC,
    parameter int unsigned INST_WIDTH  = DEF_INST_WIDTH,
    parameter int unsigned FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int unsigned NUM_BANKS   = DEF_NUM_BANKS,
    parameter int unsigned BLOCK_INSTS = DEF_BLOCK_INSTS
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        flush_i,
    input  logic [SIZE_PC-1:0]                          pc_i,
    input  logic                                        req_valid_i,
    output logic                                        req_ready_o,
    input  logic [NUM_BANKS*BLOCK_INSTS*INST_WIDTH-1:0] bank_data_i,
    input  logic [NUM_BANKS-1:0]                        bank_valid_i,
    input  logic                                        taken_valid_i,
    input  logic [$clog2(FETCH_WIDTH)-1:0]              taken_slot_i,
    output logic                                        out_valid_o,
    input  logic                                        out_ready_i,
    output logic [FETCH_WIDTH*INST_WIDTH-1:0]           out_inst_o,
    output logic [FETCH_WIDTH-1:0]                      out_mask_o,
    output logic [SIZE_PC-1:0]                          out_pc_o,
    output logic [$clog2(FETCH_WIDTH):0]                out_count_o,
    output logic [SIZE_PC-1:0]                          seq_pc_o,
    output logic                                        miss_o
);

    localparam int unsigned CNT_W = $clog2(FETCH_WIDTH) + 1;

    typedef struct packed {
        logic [FETCH_WIDTH*INST_WIDTH-1:0] inst;
        logic [FETCH_WIDTH-1:0]            mask;
        logic [SIZE_PC-1:0]                pc;
        logic [CNT_W-1:0]                  count;
    } bundle_t;

    occ_e    occ_q, occ_d;
    bundle_t head_q, head_d;
    bundle_t tail_q, tail_d;
    bundle_t new_b;
    logic    ready_q, ready_d;
    logic    miss_q, miss_d;
    logic    accept, push, pop;

    logic [FETCH_WIDTH*INST_WIDTH-1:0] al_inst;
    logic [FETCH_WIDTH-1:0]            al_mask;
    logic [CNT_W-1:0]                  al_count;

    fetch_align_rotate #(
        .SIZE_PC     (SIZE_PC),
        .INST_WIDTH  (INST_WIDTH),
        .FETCH_WIDTH (FETCH_WIDTH),
        .NUM_BANKS   (NUM_BANKS),
        .BLOCK_INSTS (BLOCK_INSTS)
    ) u_rotate (
        .pc_i          (pc_i),
        .bank_data_i   (bank_data_i),
        .bank_valid_i  (bank_valid_i),
        .taken_valid_i (taken_valid_i),
        .taken_slot_i  (taken_slot_i),
        .inst_o        (al_inst),
        .mask_o        (al_mask),
        .count_o       (al_count)
    );

    // Queue next-state: flush wins, then push/pop by occupancy; head is always slot 0.
    always_comb begin
        new_b  = '{inst: al_inst, mask: al_mask, pc: pc_i, count: al_count};
        accept = req_valid_i & ready_q & ~flush_i;
        push   = accept & (al_count != '0);
        pop    = (occ_q != OCC_EMPTY) & out_ready_i & ~flush_i;
        miss_d = accept & (al_count == '0);
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush_i) begin
            occ_d  = OCC_EMPTY;
            head_d = '0;
            tail_d = '0;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_d = new_b;
                        occ_d  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_d = new_b;
                    end else if (push) begin
                        tail_d = new_b;
                        occ_d  = OCC_FULL;
                    end else if (pop) begin
                        head_d = '0;
                        occ_d  = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_d = tail_q;
                        tail_d = '0;
                        occ_d  = OCC_ONE;
                    end
                end
                default: begin
                    occ_d  = OCC_EMPTY;
                    head_d = '0;
                    tail_d = '0;
                end
            endcase
        end
        ready_d = (occ_d != OCC_FULL);
    end

    // State registers; ready is registered so it never depends on out_ready_i.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q   <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
            miss_q  <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
            miss_q  <= miss_d;
        end
    end

    assign req_ready_o = ready_q;
    assign miss_o      = miss_q;
    assign out_valid_o = (occ_q != OCC_EMPTY);
    assign out_inst_o  = head_q.inst;
    assign out_mask_o  = head_q.mask;
    assign out_pc_o    = head_q.pc;
    assign out_count_o = head_q.count;
    assign seq_pc_o    = head_q.pc + (SIZE_PC'(head_q.count) << 2);

endmodule

// File: tb/tb_fetch_select_align.sv
// Scoreboard bench for fetch_select_align with directed vectors.
module tb_fetch_select_align;
    import fetch_select_align_pkg::*;

    typedef struct {
        logic [127:0] inst;
        logic [3:0]   mask;
        logic [31:0]  pc;
        logic [2:0]   count;
        logic [31:0]  seq;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         flush_i;
    logic [31:0]  pc_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [255:0] bank_data_i;
    logic [1:0]   bank_valid_i;
    logic         taken_valid_i;
    logic [1:0]   taken_slot_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] out_inst_o;
    logic [3:0]   out_mask_o;
    logic [31:0]  out_pc_o;
    logic [2:0]   out_count_o;
    logic [31:0]  seq_pc_o;
    logic         miss_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t expq[$];
    exp_t mon_e;

    fetch_select_align #(
        .SIZE_PC     (32),
        .INST_WIDTH  (32),
        .FETCH_WIDTH (4),
        .NUM_BANKS   (2),
        .BLOCK_INSTS (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush_i       (flush_i),
        .pc_i          (pc_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .bank_data_i   (bank_data_i),
        .bank_valid_i  (bank_valid_i),
        .taken_valid_i (taken_valid_i),
        .taken_slot_i  (taken_slot_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_inst_o    (out_inst_o),
        .out_mask_o    (out_mask_o),
        .out_pc_o      (out_pc_o),
        .out_count_o   (out_count_o),
        .seq_pc_o      (seq_pc_o),
        .miss_o        (miss_o)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [127:0] inst, input logic [3:0] mask,
                            input logic [31:0] pc, input logic [2:0] cnt,
                            input logic [31:0] seq);
        exp_t e;
        e.inst = inst; e.mask = mask; e.pc = pc; e.count = cnt; e.seq = seq;
        expq.push_back(e);
    endtask

    task automatic send(input logic [31:0] pc, input logic [1:0] bv,
                        input logic tv, input logic [1:0] ts);
        pc_i          = pc;
        bank_valid_i  = bv;
        taken_valid_i = tv;
        taken_slot_i  = ts;
        req_valid_i   = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i   = 1'b0;
        bank_valid_i  = 2'b11;
        taken_valid_i = 1'b0;
        taken_slot_i  = 2'd0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 128'(out_valid_o), 128'd0);
        chk({tag, "_ready"}, 128'(req_ready_o), 128'd1);
        chk({tag, "_miss"},  128'(miss_o),      128'd0);
        chk({tag, "_inst"},  out_inst_o,        128'd0);
        chk({tag, "_mask"},  128'(out_mask_o),  128'd0);
        chk({tag, "_pc"},    128'(out_pc_o),    128'd0);
        chk({tag, "_count"}, 128'(out_count_o), 128'd0);
        chk({tag, "_seq"},   128'(seq_pc_o),    128'd0);
    endtask

    // Monitor: every head transfer is compared against the oldest expected bundle.
    always @(negedge clk) begin
        if (reset_n && out_valid_o && out_ready_i && !flush_i) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=pc %h required=no output", out_pc_o);
            end else begin
                mon_e = expq.pop_front();
                chk("out_inst",  out_inst_o,        mon_e.inst);
                chk("out_mask",  128'(out_mask_o),  128'(mon_e.mask));
                chk("out_pc",    128'(out_pc_o),    128'(mon_e.pc));
                chk("out_count", 128'(out_count_o), 128'(mon_e.count));
                chk("seq_pc",    128'(seq_pc_o),    128'(mon_e.seq));
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        flush_i       = 1'b0;
        pc_i          = '0;
        req_valid_i   = 1'b0;
        bank_valid_i  = 2'b11;
        taken_valid_i = 1'b0;
        taken_slot_i  = 2'd0;
        out_ready_i   = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                bank_data_i[(b*4+k)*32 +: 32] = ((b == 0) ? 32'hA0 : 32'hB0) + 32'(k);
            end
        end

        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Aligned across the bank boundary, one-cycle latency.
        push_exp({32'hB1, 32'hB0, 32'hA3, 32'hA2}, 4'b1111, 32'h1008, 3'd4, 32'h1018);
        send(32'h1008, 2'b11, 1'b0, 2'd0);
        @(negedge clk);
        chk("latency_valid", 128'(out_valid_o), 128'd1);

        // Start in bank 1, wrap into bank 0; then bank 0 missing; then taken truncation.
        push_exp({32'hA2, 32'hA1, 32'hA0, 32'hB3}, 4'b1111, 32'h101C, 3'd4, 32'h102C);
        send(32'h101C, 2'b11, 1'b0, 2'd0);
        push_exp({32'h0, 32'h0, 32'h0, 32'hB3}, 4'b0001, 32'h101C, 3'd1, 32'h1020);
        send(32'h101C, 2'b10, 1'b0, 2'd0);
        push_exp({32'h0, 32'h0, 32'hA3, 32'hA2}, 4'b0011, 32'h1008, 3'd2, 32'h1010);
        send(32'h1008, 2'b11, 1'b1, 2'd1);

        // First bank invalid: miss pulse, nothing enqueued.
        send(32'h1008, 2'b10, 1'b0, 2'd0);
        @(negedge clk);
        chk("miss_pulse", 128'(miss_o), 128'd1);
        chk("miss_no_enq", 128'(out_valid_o), 128'd0);
        @(negedge clk);
        chk("miss_one_cycle", 128'(miss_o), 128'd0);

        // Back-pressure: two queued, third refused, then drained in order.
        @(posedge clk);
        #1 out_ready_i = 1'b0;
        push_exp({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b1111, 32'h1000, 3'd4, 32'h1010);
        send(32'h1000, 2'b11, 1'b0, 2'd0);
        chk("ready_after_one", 128'(req_ready_o), 128'd1);
        push_exp({32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b1111, 32'h1010, 3'd4, 32'h1020);
        send(32'h1010, 2'b11, 1'b0, 2'd0);
        @(negedge clk);
        chk("full_ready_low", 128'(req_ready_o), 128'd0);
        pc_i        = 32'h1020;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("full_still_low", 128'(req_ready_o), 128'd0);
        chk("full_head_valid", 128'(out_pc_o), 128'h1000);
        @(posedge clk);
        #1 out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("third_dropped", 128'(out_valid_o), 128'd0);

        // Flush with a full queue and a same-cycle request.
        @(posedge clk);
        #1 out_ready_i = 1'b0;
        push_exp({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b1111, 32'h1000, 3'd4, 32'h1010);
        send(32'h1000, 2'b11, 1'b0, 2'd0);
        push_exp({32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b1111, 32'h1010, 3'd4, 32'h1020);
        send(32'h1010, 2'b11, 1'b0, 2'd0);
        flush_i     = 1'b1;
        pc_i        = 32'h1030;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        expq.delete();
        @(negedge clk);
        chk("flush_valid", 128'(out_valid_o), 128'd0);
        chk("flush_ready", 128'(req_ready_o), 128'd1);
        @(negedge clk);
        chk("flush_req_dropped", 128'(out_valid_o), 128'd0);

        // Asynchronous reset mid-cycle with two entries queued.
        @(posedge clk);
        #1;
        push_exp({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b1111, 32'h1000, 3'd4, 32'h1010);
        send(32'h1000, 2'b11, 1'b0, 2'd0);
        push_exp({32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b1111, 32'h1010, 3'd4, 32'h1020);
        send(32'h1010, 2'b11, 1'b0, 2'd0);
        chk("pre_reset_valid", 128'(out_valid_o), 128'd1);
        #2 reset_n = 1'b0;
        expq.delete();
        #1;
        chk_zero_outputs("async_reset");
        @(posedge clk);
        #1;
        reset_n     = 1'b1;
        out_ready_i = 1'b1;

        // Normal operation resumes after reset.
        push_exp({32'hB1, 32'hB0, 32'hA3, 32'hA2}, 4'b1111, 32'h1008, 3'd4, 32'h1018);
        send(32'h1008, 2'b11, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        chk("queue_drained", 128'(expq.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_select_align.md
Name: fetch_select_align

Overview:
- Parametrised fetch-bundle selector/aligner; sits between the banked L1 I-cache read stage and decode.
- Derives start bank and first-instruction offset from the fetch PC, rotates and shifts the NUM_BANKS cache blocks into a contiguous bundle of up to FETCH_WIDTH instructions, truncates on predicted-taken slot or bank miss, and buffers results in a 2-entry skid queue with valid/ready handshake and flush.

Parameters:
- SIZE_PC, 32, PC width in bits.
- INST_WIDTH, 32, instruction width in bits; instructions are 4-byte aligned.
- FETCH_WIDTH, 4, maximum instructions per output bundle; power of 2, at most NUM_BANKS*BLOCK_INSTS.
- NUM_BANKS, 2, interleaved cache banks; power of 2, at least 2.
- BLOCK_INSTS, 4, instructions per bank block; power of 2.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discards all queued bundles and any same-cycle request.
- pc_i  in  SIZE_PC  fetch PC of the request.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted this cycle when high with req_valid_i.
- bank_data_i  in  NUM_BANKS*BLOCK_INSTS*INST_WIDTH  block b at bits [b*BLOCK_INSTS*INST_WIDTH +: BLOCK_INSTS*INST_WIDTH]; slot 0 is least significant.
- bank_valid_i  in  NUM_BANKS  per-bank hit.
- taken_valid_i  in  1  predictor marks a taken branch in the bundle.
- taken_slot_i  in  log2(FETCH_WIDTH)  bundle slot of that branch.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer accepts head.
- out_inst_o  out  FETCH_WIDTH*INST_WIDTH  aligned instructions; slot 0 least significant.
- out_mask_o  out  FETCH_WIDTH  per-slot valid, thermometer from bit 0.
- out_pc_o  out  SIZE_PC  PC of slot 0.
- out_count_o  out  log2(FETCH_WIDTH)+1  number of valid slots.
- seq_pc_o  out  SIZE_PC  head fall-through PC: out_pc_o + 4*out_count_o.
- miss_o  out  1  one-cycle pulse when an accepted request has its first bank invalid.

Behaviour:
- Decode of pc_i:
  - first = pc_i[2 +: log2(BLOCK_INSTS)]
  - start = pc_i[2+log2(BLOCK_INSTS) +: log2(NUM_BANKS)]
- Window: W = NUM_BANKS*BLOCK_INSTS instructions, taken from banks start, start+1, ... modulo NUM_BANKS. The cache presents consecutive block addresses, so wrapped banks hold the next row.
- Candidate slot i = window[first+i].
- avail = min(FETCH_WIDTH, W - first).
- Miss truncation: bank_limit = index of the first slot lying in an invalid bank, else avail.
- Taken truncation: taken_limit = taken_slot_i+1 if taken_valid_i, else FETCH_WIDTH.
- count = min(avail, bank_limit, taken_limit).
- mask bit i = (i < count). Slots at or above count are driven 0.
- Accept = req_valid_i & req_ready_o & !flush_i.
  - count==0 (first bank invalid): pulse miss_o next cycle; nothing enqueued.
  - Otherwise: enqueue {inst, mask, pc_i, count} at the tail.
- Latency: accept at cycle N gives out_valid_o at N+1 when the queue was empty.
- Queue: 2 entries, FIFO order, occupancy 0/1/2.
  - req_ready_o = (occupancy < 2), registered; no combinational path from out_ready_i.
  - Pop when out_valid_o & out_ready_i.
  - Push and pop in the same cycle at occupancy 1: occupancy stays 1, new entry becomes head next cycle.
  - At occupancy 2, ready is low and no push occurs.
- Flush has priority over push and pop: occupancy goes to 0 next cycle; miss_o goes low; req_ready_o is high the cycle after.
- seq_pc_o is computed combinationally from the head entry; SIZE_PC arithmetic wraps modulo 2^SIZE_PC.
- Reset (asynchronous, any time, including mid-operation):
  - occupancy 0, out_valid_o 0, req_ready_o 1, miss_o 0.
  - out_inst_o, out_mask_o, out_pc_o, out_count_o, seq_pc_o all 0.
- Output payload is held stable while out_valid_o & !out_ready_i.

Decomposition:
- Shared fetch package holds:
  - derived constants: FIRST_BITS = log2(BLOCK_INSTS), BANK_BITS = log2(NUM_BANKS), CNT_BITS = log2(FETCH_WIDTH)+1
  - fetch_bundle_t packed struct {inst, mask, pc, count}
- One sub-module: fetch_align_rotate, a purely combinational unit that performs the window rotate/shift and limit computation.
- The top level holds the 2-entry queue, handshake and miss pulse.

Test Plan (defaults; bank0 slot k = 0xA0+k, bank1 slot k = 0xB0+k; all banks valid, out_ready_i=1 unless stated):
- pc=0x1008 -> next cycle out_inst = {B1,B0,A3,A2}, mask=1111, count=4, out_pc=0x1008, seq_pc=0x1018.
- pc=0x101C (start=1, first=3) -> {A2,A1,A0,B3}, count=4. Same pc with bank0 invalid -> {0,0,0,B3}, count=1.
- pc=0x1008, taken_valid=1, slot=1 -> mask=0011, count=2, seq_pc=0x1010. pc=0x1008 with bank0 invalid -> no enqueue, miss_o pulses 1 cycle.
- out_ready=0, three back-to-back requests (pc 0x1000, 0x1010, 0x1020) -> 2 queued, req_ready_o low from cycle 2, third not accepted. Raise out_ready -> heads 0x1000 then 0x1010 in order.
- Queue full, flush_i with req_valid_i=1 -> out_valid 0 next cycle, request dropped, req_ready_o 1.
- Assert reset_n=0 mid-cycle with 2 entries queued -> out_valid 0 and outputs 0 immediately (asynchronous), req_ready_o 1.
